// File: rtl/control_pipe_unit.sv
// RV32IM ID/EX control stage: decodes IF/ID through control_unit and registers the bundle.
// Also handles flush/hazard bubbles and the multi-cycle M-extension EX occupancy.

module control_unit (
  input  logic [31:0] INSTRUCTION,
  output logic        OP1_SEL,
  output logic        OP2_SEL,
  output logic        REG_WRITE_EN,
  output logic [3:0]  IMM_SEL,
  output logic [3:0]  BR_SEL,
  output logic [4:0]  ALU_OP,
  output logic [2:0]  MEM_WRITE,
  output logic [3:0]  MEM_READ,
  output logic [1:0]  REG_WRITE_SEL
);
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  localparam logic [3:0] IMM_I = 4'd1;
  localparam logic [3:0] IMM_S = 4'd2;
  localparam logic [3:0] IMM_B = 4'd3;
  localparam logic [3:0] IMM_U = 4'd4;
  localparam logic [3:0] IMM_J = 4'd5;

  localparam logic [1:0] RWS_MEM = 2'd1;
  localparam logic [1:0] RWS_PC4 = 2'd2;

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic       unused_fields;

  assign opcode        = INSTRUCTION[6:0];
  assign funct3        = INSTRUCTION[14:12];
  assign funct7        = INSTRUCTION[31:25];
  assign unused_fields = ^{INSTRUCTION[24:15], INSTRUCTION[11:7]};

  // ALU_OP: {M, alt, funct3}; M ops use 2'b10 prefix, 5'b11111 passes op2 (LUI)
  always_comb begin
    OP1_SEL       = 1'b0;
    OP2_SEL       = 1'b0;
    REG_WRITE_EN  = 1'b0;
    IMM_SEL       = '0;
    BR_SEL        = '0;
    ALU_OP        = '0;
    MEM_WRITE     = '0;
    MEM_READ      = '0;
    REG_WRITE_SEL = '0;
    case (opcode)
      OPC_OP: begin
        REG_WRITE_EN = 1'b1;
        ALU_OP       = (funct7 == 7'b0000001) ? {2'b10, funct3} : {1'b0, INSTRUCTION[30], funct3};
      end
      OPC_OPIMM: begin
        OP2_SEL      = 1'b1;
        REG_WRITE_EN = 1'b1;
        IMM_SEL      = IMM_I;
        ALU_OP       = {1'b0, (funct3 == 3'b101) & INSTRUCTION[30], funct3};
      end
      OPC_LOAD: begin
        OP2_SEL       = 1'b1;
        REG_WRITE_EN  = 1'b1;
        IMM_SEL       = IMM_I;
        MEM_READ      = {1'b1, funct3};
        REG_WRITE_SEL = RWS_MEM;
      end
      OPC_STORE: begin
        OP2_SEL   = 1'b1;
        IMM_SEL   = IMM_S;
        MEM_WRITE = (funct3 == 3'b000) ? 3'b001 : (funct3 == 3'b001) ? 3'b010 : 3'b100;
      end
      OPC_BRANCH: begin
        IMM_SEL = IMM_B;
        BR_SEL  = {1'b1, funct3};
        ALU_OP  = 5'b01000;
      end
      OPC_JAL: begin
        OP1_SEL       = 1'b1;
        OP2_SEL       = 1'b1;
        REG_WRITE_EN  = 1'b1;
        IMM_SEL       = IMM_J;
        BR_SEL        = 4'b0010;
        REG_WRITE_SEL = RWS_PC4;
      end
      OPC_JALR: begin
        OP2_SEL       = 1'b1;
        REG_WRITE_EN  = 1'b1;
        IMM_SEL       = IMM_I;
        BR_SEL        = 4'b0011;
        REG_WRITE_SEL = RWS_PC4;
      end
      OPC_LUI: begin
        OP2_SEL      = 1'b1;
        REG_WRITE_EN = 1'b1;
        IMM_SEL      = IMM_U;
        ALU_OP       = 5'b11111;
      end
      OPC_AUIPC: begin
        OP1_SEL      = 1'b1;
        OP2_SEL      = 1'b1;
        REG_WRITE_EN = 1'b1;
        IMM_SEL      = IMM_U;
      end
      default: ;
    endcase
  end
endmodule

module control_pipe_unit #(
  parameter int unsigned MUL_CYCLES = 2,
  parameter int unsigned DIV_CYCLES = 34,
  parameter int unsigned CNT_W      = $clog2((MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES) + 1
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [31:0] INSTRUCTION,
  input  logic        INSTR_VALID,
  input  logic        FLUSH,
  input  logic        HAZARD_STALL,
  output logic        OP1_SEL,
  output logic        OP2_SEL,
  output logic        REG_WRITE_EN,
  output logic [3:0]  IMM_SEL,
  output logic [3:0]  BR_SEL,
  output logic [4:0]  ALU_OP,
  output logic [2:0]  MEM_WRITE,
  output logic [3:0]  MEM_READ,
  output logic [1:0]  REG_WRITE_SEL,
  output logic        EX_VALID,
  output logic        MD_START,
  output logic        MD_DONE,
  output logic        STALL_OUT
);
  typedef struct packed {
    logic       op1_sel;
    logic       op2_sel;
    logic       reg_write_en;
    logic [3:0] imm_sel;
    logic [3:0] br_sel;
    logic [4:0] alu_op;
    logic [2:0] mem_write;
    logic [3:0] mem_read;
    logic [1:0] reg_write_sel;
  } bundle_t;

  typedef enum logic {S_IDLE, S_RUN} state_e;

  localparam logic [CNT_W-1:0] MUL_LAST = CNT_W'(MUL_CYCLES - 1);
  localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(DIV_CYCLES - 1);

  logic       dec_op1_sel, dec_op2_sel, dec_reg_write_en;
  logic [3:0] dec_imm_sel, dec_br_sel, dec_mem_read;
  logic [4:0] dec_alu_op;
  logic [2:0] dec_mem_write;
  logic [1:0] dec_reg_write_sel;

  control_unit u_dec (
    .INSTRUCTION   (INSTRUCTION),
    .OP1_SEL       (dec_op1_sel),
    .OP2_SEL       (dec_op2_sel),
    .REG_WRITE_EN  (dec_reg_write_en),
    .IMM_SEL       (dec_imm_sel),
    .BR_SEL        (dec_br_sel),
    .ALU_OP        (dec_alu_op),
    .MEM_WRITE     (dec_mem_write),
    .MEM_READ      (dec_mem_read),
    .REG_WRITE_SEL (dec_reg_write_sel)
  );

  bundle_t          bundle_q, bundle_d, dec_bundle;
  logic             ex_valid_q, ex_valid_d;
  logic             ex_is_md_q, ex_is_md_d;
  logic             md_start_q, md_start_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  state_e           state;
  logic             is_md, stall;

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      bundle_q   <= '0;
      ex_valid_q <= 1'b0;
      ex_is_md_q <= 1'b0;
      md_start_q <= 1'b0;
      cnt_q      <= '0;
    end else begin
      bundle_q   <= bundle_d;
      ex_valid_q <= ex_valid_d;
      ex_is_md_q <= ex_is_md_d;
      md_start_q <= md_start_d;
      cnt_q      <= cnt_d;
    end
  end

  always_comb begin
    dec_bundle.op1_sel       = dec_op1_sel;
    dec_bundle.op2_sel       = dec_op2_sel;
    dec_bundle.reg_write_en  = dec_reg_write_en;
    dec_bundle.imm_sel       = dec_imm_sel;
    dec_bundle.br_sel        = dec_br_sel;
    dec_bundle.alu_op        = dec_alu_op;
    dec_bundle.mem_write     = dec_mem_write;
    dec_bundle.mem_read      = dec_mem_read;
    dec_bundle.reg_write_sel = dec_reg_write_sel;
  end

  // Occupancy state is implied by the remaining-cycle counter
  always_comb begin
    state = (cnt_q == '0) ? S_IDLE : S_RUN;
    stall = ex_valid_q & ex_is_md_q & (state == S_RUN);
    is_md = (INSTRUCTION[6:0] == 7'b0110011) && (INSTRUCTION[31:25] == 7'b0000001);

    bundle_d   = bundle_q;
    ex_valid_d = ex_valid_q;
    ex_is_md_d = ex_is_md_q;
    cnt_d      = cnt_q;
    md_start_d = 1'b0;

    if (FLUSH) begin
      bundle_d   = '0;
      ex_valid_d = 1'b0;
      ex_is_md_d = 1'b0;
      cnt_d      = '0;
    end else if (stall) begin
      cnt_d = cnt_q - CNT_W'(1);
    end else if (HAZARD_STALL || !INSTR_VALID) begin
      bundle_d   = '0;
      ex_valid_d = 1'b0;
      ex_is_md_d = 1'b0;
      cnt_d      = '0;
    end else begin
      bundle_d   = dec_bundle;
      ex_valid_d = 1'b1;
      ex_is_md_d = is_md;
      cnt_d      = is_md ? (INSTRUCTION[14] ? DIV_LAST : MUL_LAST) : '0;
      md_start_d = is_md;
    end
  end

  assign OP1_SEL       = bundle_q.op1_sel;
  assign OP2_SEL       = bundle_q.op2_sel;
  assign REG_WRITE_EN  = bundle_q.reg_write_en & ~stall;
  assign IMM_SEL       = bundle_q.imm_sel;
  assign BR_SEL        = bundle_q.br_sel;
  assign ALU_OP        = bundle_q.alu_op;
  assign MEM_WRITE     = bundle_q.mem_write & {3{~stall}};
  assign MEM_READ      = bundle_q.mem_read & {4{~stall}};
  assign REG_WRITE_SEL = bundle_q.reg_write_sel;
  assign EX_VALID      = ex_valid_q;
  assign MD_START      = md_start_q;
  assign MD_DONE       = ex_valid_q & ex_is_md_q & (state == S_IDLE);
  assign STALL_OUT     = stall;
endmodule

// File: tb/tb_control_pipe_unit.sv
module tb_control_pipe_unit;
  localparam logic [31:0] I_ADD = 32'h002081B3;
  localparam logic [31:0] I_MUL = 32'h022081B3;
  localparam logic [31:0] I_DIV = 32'h0220C1B3;
  localparam logic [31:0] I_LW  = 32'h0000A183;
  localparam logic [31:0] I_SW  = 32'h0020A223;

  localparam logic [24:0] B_ADD = {1'b0, 1'b0, 1'b1, 4'd0, 4'd0, 5'd0, 3'd0, 4'd0, 2'd0};
  localparam logic [24:0] B_LW  = {1'b0, 1'b1, 1'b1, 4'd1, 4'd0, 5'd0, 3'd0, 4'b1010, 2'd1};
  localparam logic [24:0] B_SW  = {1'b0, 1'b1, 1'b0, 4'd2, 4'd0, 5'd0, 3'b100, 4'd0, 2'd0};
  localparam logic [4:0]  A_MUL = 5'b10000;
  localparam logic [4:0]  A_DIV = 5'b10100;
  localparam logic [28:0] BUB   = '0;

  logic        CLK, RESET, INSTR_VALID, FLUSH, HAZARD_STALL;
  logic [31:0] INSTRUCTION;
  logic        OP1_SEL, OP2_SEL, REG_WRITE_EN, EX_VALID, MD_START, MD_DONE, STALL_OUT;
  logic [3:0]  IMM_SEL, BR_SEL, MEM_READ;
  logic [4:0]  ALU_OP;
  logic [2:0]  MEM_WRITE;
  logic [1:0]  REG_WRITE_SEL;
  logic [28:0] obs;

  control_pipe_unit #(.MUL_CYCLES(2), .DIV_CYCLES(34)) dut (
    .CLK           (CLK),
    .RESET         (RESET),
    .INSTRUCTION   (INSTRUCTION),
    .INSTR_VALID   (INSTR_VALID),
    .FLUSH         (FLUSH),
    .HAZARD_STALL  (HAZARD_STALL),
    .OP1_SEL       (OP1_SEL),
    .OP2_SEL       (OP2_SEL),
    .REG_WRITE_EN  (REG_WRITE_EN),
    .IMM_SEL       (IMM_SEL),
    .BR_SEL        (BR_SEL),
    .ALU_OP        (ALU_OP),
    .MEM_WRITE     (MEM_WRITE),
    .MEM_READ      (MEM_READ),
    .REG_WRITE_SEL (REG_WRITE_SEL),
    .EX_VALID      (EX_VALID),
    .MD_START      (MD_START),
    .MD_DONE       (MD_DONE),
    .STALL_OUT     (STALL_OUT)
  );

  assign obs = {EX_VALID, MD_START, MD_DONE, STALL_OUT, OP1_SEL, OP2_SEL, REG_WRITE_EN,
                IMM_SEL, BR_SEL, ALU_OP, MEM_WRITE, MEM_READ, REG_WRITE_SEL};

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic [28:0] exp_q[$];
  string       name_q[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  event        chk_now;

  function automatic logic [28:0] vld(input logic [24:0] b);
    return {1'b1, 1'b0, 1'b0, 1'b0, b};
  endfunction

  function automatic logic [28:0] mdr(input logic ms, input logic md, input logic st,
                                      input logic [4:0] alu);
    return {1'b1, ms, md, st, 1'b0, 1'b0, ~st, 4'd0, 4'd0, alu, 3'd0, 4'd0, 2'd0};
  endfunction

  always @(negedge CLK or chk_now) begin
    if (exp_q.size() > 0) begin
      logic [28:0] e;
      string       nm;
      e  = exp_q.pop_front();
      nm = name_q.pop_front();
      n_checks++;
      if (obs !== e) begin
        n_fail++;
        $display("FAIL %s: got %h expected %h", nm, obs, e);
      end
    end
  end

  task automatic cyc(input logic [31:0] ins, input logic v, input logic fl, input logic hz,
                     input logic [28:0] e, input string nm);
    @(negedge CLK);
    #1;
    INSTRUCTION  = ins;
    INSTR_VALID  = v;
    FLUSH        = fl;
    HAZARD_STALL = hz;
    exp_q.push_back(e);
    name_q.push_back(nm);
    @(posedge CLK);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    RESET = 1'b0; INSTRUCTION = I_MUL; INSTR_VALID = 1'b1; FLUSH = 1'b0; HAZARD_STALL = 1'b0;

    for (int i = 0; i < 3; i++) cyc(I_MUL, 1'b1, 1'b0, 1'b0, BUB, "reset_hold");
    RESET = 1'b1;
    cyc(I_MUL, 1'b1, 1'b0, 1'b0, mdr(1'b1, 1'b0, 1'b1, A_MUL), "rst_rel_mul_start");
    cyc(I_ADD, 1'b1, 1'b0, 1'b0, mdr(1'b0, 1'b1, 1'b0, A_MUL), "rst_rel_mul_done");

    for (int i = 0; i < 3; i++) cyc(I_ADD, 1'b1, 1'b0, 1'b0, vld(B_ADD), "add");

    cyc(I_MUL, 1'b1, 1'b0, 1'b0, mdr(1'b1, 1'b0, 1'b1, A_MUL), "mul_start");
    cyc(I_DIV, 1'b1, 1'b0, 1'b0, mdr(1'b0, 1'b1, 1'b0, A_MUL), "mul_done");
    cyc(I_DIV, 1'b1, 1'b0, 1'b0, mdr(1'b1, 1'b0, 1'b1, A_DIV), "div_start");
    for (int k = 0; k < 32; k++)
      cyc(I_ADD, 1'b1, 1'b0, (k % 4) == 0, mdr(1'b0, 1'b0, 1'b1, A_DIV), "div_run");
    cyc(I_ADD, 1'b1, 1'b0, 1'b0, mdr(1'b0, 1'b1, 1'b0, A_DIV), "div_done");
    cyc(I_ADD, 1'b1, 1'b0, 1'b0, vld(B_ADD), "add_after_div");

    cyc(I_LW, 1'b1, 1'b0, 1'b0, vld(B_LW), "lw");
    cyc(I_SW, 1'b1, 1'b0, 1'b0, vld(B_SW), "sw");

    cyc(I_ADD, 1'b1, 1'b0, 1'b1, BUB, "hazard_bubble");
    cyc(I_ADD, 1'b1, 1'b0, 1'b0, vld(B_ADD), "hazard_then_add");
    cyc(I_ADD, 1'b0, 1'b0, 1'b0, BUB, "invalid_bubble");

    cyc(I_DIV, 1'b1, 1'b0, 1'b0, mdr(1'b1, 1'b0, 1'b1, A_DIV), "flush_div_start");
    for (int k = 0; k < 9; k++)
      cyc(I_ADD, 1'b1, 1'b0, 1'b0, mdr(1'b0, 1'b0, 1'b1, A_DIV), "flush_div_run");
    cyc(I_ADD, 1'b1, 1'b1, 1'b0, BUB, "flush_bubble");
    cyc(I_ADD, 1'b1, 1'b0, 1'b0, vld(B_ADD), "add_after_flush");

    cyc(I_DIV, 1'b1, 1'b0, 1'b0, mdr(1'b1, 1'b0, 1'b1, A_DIV), "arst_div_start");
    for (int k = 0; k < 4; k++)
      cyc(I_ADD, 1'b1, 1'b0, 1'b0, mdr(1'b0, 1'b0, 1'b1, A_DIV), "arst_div_run");
    @(negedge CLK);
    #1;
    RESET = 1'b0;
    #1;
    n_checks++;
    if (obs !== BUB) begin
      n_fail++;
      $display("FAIL async_reset_direct: got %h expected %h", obs, BUB);
    end
    exp_q.push_back(BUB);
    name_q.push_back("async_reset_immediate");
    ->chk_now;
    #1;
    for (int i = 0; i < 2; i++) cyc(I_ADD, 1'b1, 1'b0, 1'b0, BUB, "arst_hold");
    RESET = 1'b1;
    cyc(I_ADD, 1'b1, 1'b0, 1'b0, vld(B_ADD), "add_after_arst");
    n_checks++;
    if (EX_VALID !== 1'b1 || STALL_OUT !== 1'b0) begin
      n_fail++;
      $display("FAIL add_after_arst_direct: got ex_valid=%b stall=%b expected ex_valid=1 stall=0",
               EX_VALID, STALL_OUT);
    end
    cyc(I_ADD, 1'b0, 1'b0, 1'b0, BUB, "final_bubble");
    n_checks++;
    if (EX_VALID !== 1'b0 || MD_DONE !== 1'b0) begin
      n_fail++;
      $display("FAIL final_bubble_direct: got ex_valid=%b md_done=%b expected 0 0",
               EX_VALID, MD_DONE);
    end

    @(negedge CLK);
    #2;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
